// File: rtl/ram_port_arbiter_pkg.sv
// Shared types for RAM port arbitration.
// Tag layout is sized for the largest supported arbiter.
package ram_port_arbiter_pkg;

  localparam int NREQ_MAX = 8;
  localparam int PTR_W    = $clog2(NREQ_MAX);

  typedef struct packed {
    logic             valid;
    logic             rd;
    logic [PTR_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/rr_find_first.sv
// Rotating first-one finder.
// Scans req&mask from start with wrap.
module rr_find_first #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] start_i,
  input  logic [N-1:0] mask_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  // Walk backwards so the nearest hit to start wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = start_i + W'(k);
      if (req_i[cand] && mask_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin arbiter for a shared
// dual-port RAM with read-data return.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            we,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [NREQ*DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0]      ram_addr_a,
  output logic [ADDR_WIDTH-1:0]      ram_addr_b,
  output logic [DATA_WIDTH-1:0]      ram_data_a,
  output logic [DATA_WIDTH-1:0]      ram_data_b,
  output logic                       ram_we_a,
  output logic                       ram_we_b,
  input  logic [DATA_WIDTH-1:0]      ram_q_a,
  input  logic [DATA_WIDTH-1:0]      ram_q_b
);

  localparam int PW = $clog2(NREQ);

  logic [ADDR_WIDTH-1:0] addr_u  [NREQ];
  logic [DATA_WIDTH-1:0] wdata_u [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_u[i]  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_u[i] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   a_idx, b_idx, b_start;
  logic            a_found, b_found;
  logic            a_ok, b_ok;
  logic [NREQ-1:0] mask_b, req_b;
  tag_t            tag_a_q, tag_a_d;
  tag_t            tag_b_q, tag_b_d;
  logic [NREQ-1:0] rvalid_q, rvalid_d;
  logic [NREQ*DATA_WIDTH-1:0] rdata_q, rdata_d;

  rr_find_first #(.N(NREQ), .W(PW)) u_find_a (
    .req_i   (req),
    .start_i (ptr_q),
    .mask_i  ({NREQ{1'b1}}),
    .found_o (a_found),
    .idx_o   (a_idx)
  );

  // Port B excludes A and anything hazarding with A.
  always_comb begin
    mask_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      mask_b[j] = (PW'(j) != a_idx) &&
                  !((addr_u[j] == addr_u[a_idx]) &&
                    (we[a_idx] || we[j]));
    end
  end

  assign req_b   = req & {NREQ{a_found}};
  assign b_start = a_idx + PW'(1);

  rr_find_first #(.N(NREQ), .W(PW)) u_find_b (
    .req_i   (req_b),
    .start_i (b_start),
    .mask_i  (mask_b),
    .found_o (b_found),
    .idx_o   (b_idx)
  );

  assign a_ok = rst_n & a_found;
  assign b_ok = rst_n & a_found & b_found;

  // Grants and RAM port drive; idle ports drive zeros.
  always_comb begin
    gnt        = '0;
    ram_we_a   = 1'b0;
    ram_addr_a = '0;
    ram_data_a = '0;
    ram_we_b   = 1'b0;
    ram_addr_b = '0;
    ram_data_b = '0;
    if (a_ok) begin
      gnt[a_idx] = 1'b1;
      ram_we_a   = we[a_idx];
      ram_addr_a = addr_u[a_idx];
      ram_data_a = wdata_u[a_idx];
    end
    if (b_ok) begin
      gnt[b_idx] = 1'b1;
      ram_we_b   = we[b_idx];
      ram_addr_b = addr_u[b_idx];
      ram_data_b = wdata_u[b_idx];
    end
  end

  // Next pointer and tags for the cycle's grants.
  always_comb begin
    ptr_d = ptr_q;
    if (b_ok)      ptr_d = b_idx + PW'(1);
    else if (a_ok) ptr_d = a_idx + PW'(1);
    tag_a_d = '{valid: a_ok, rd: ~we[a_idx],
                idx: PTR_W'(a_idx)};
    tag_b_d = '{valid: b_ok, rd: ~we[b_idx],
                idx: PTR_W'(b_idx)};
  end

  // Route RAM output to the requester named by each tag.
  always_comb begin
    rvalid_d = '0;
    rdata_d  = rdata_q;
    for (int i = 0; i < NREQ; i++) begin
      if (tag_a_q.valid && tag_a_q.rd &&
          int'(tag_a_q.idx) == i) begin
        rvalid_d[i] = 1'b1;
        rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_a;
      end
      if (tag_b_q.valid && tag_b_q.rd &&
          int'(tag_b_q.idx) == i) begin
        rvalid_d[i] = 1'b1;
        rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = ram_q_b;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      tag_a_q  <= '0;
      tag_b_q  <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tag_a_q  <= tag_a_d;
      tag_b_q  <= tag_b_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule
